// File: rtl/sum_display_driver_if.sv
// Bus between the adder's Output stage and the display driver.
// The master drives Sum/Load; the slave (the driver) returns Busy and the segment/anode lines.
interface sum_display_driver_if #(parameter int SUM_W = 5);
    logic [SUM_W-1:0] Sum;
    logic             Load;
    logic             Busy;
    logic [6:0]       Seg;
    logic [3:0]       An;

    modport master (output Sum, Load, input Busy, Seg, An);
    modport slave  (input Sum, Load, output Busy, Seg, An);
endinterface

// File: rtl/sum_display_driver.sv
// Captures the adder sum, converts it to two BCD digits by iterative double-dabble,
// and multiplexes them onto an active-low 2-of-4 seven-segment display. HEX_MODE_EN selects hex digits.
module sum_display_driver #(
    parameter int SUM_W       = 5,
    parameter int REFRESH_DIV = 50000
) (
    input logic                Clk,
    input logic                Rst_n,
    sum_display_driver_if.slave bus
);
    localparam int CW = $clog2(SUM_W + 1);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
`ifdef HEX_MODE_EN
    localparam logic [CW-1:0] CONV_LEN = CW'(1);
`else
    localparam logic [CW-1:0] CONV_LEN = CW'(SUM_W);
`endif

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state, state_nxt;
    logic [SUM_W-1:0] sh;
    logic [7:0]       bcd, bcd_adj, bcd_nxt;
    logic [CW-1:0]    cnt;
    logic [3:0]       tens, ones;
    logic [RW-1:0]    rcnt;
    logic             sel;

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        case (d)
            4'h0: seg_pat = 7'b1000000;
            4'h1: seg_pat = 7'b1111001;
            4'h2: seg_pat = 7'b0100100;
            4'h3: seg_pat = 7'b0110000;
            4'h4: seg_pat = 7'b0011001;
            4'h5: seg_pat = 7'b0010010;
            4'h6: seg_pat = 7'b0000010;
            4'h7: seg_pat = 7'b1111000;
            4'h8: seg_pat = 7'b0000000;
            4'h9: seg_pat = 7'b0010000;
`ifdef HEX_MODE_EN
            4'hA: seg_pat = 7'b0001000;
            4'hB: seg_pat = 7'b0000011;
            4'hC: seg_pat = 7'b1000110;
            4'hD: seg_pat = 7'b0100001;
            4'hE: seg_pat = 7'b0000110;
            4'hF: seg_pat = 7'b0001110;
`endif
            default: seg_pat = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.Load) state_nxt = CONV;
            CONV: if (cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.Busy = (state == CONV);

    // One double-dabble step: add-3 on nibbles >= 5, then shift in the next sum bit.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        bcd_nxt = {bcd_adj[6:0], sh[SUM_W-1]};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            tens <= '0;
            ones <= '0;
        end else begin
            case (state)
                IDLE: if (bus.Load) begin
                    sh  <= bus.Sum;
                    bcd <= '0;
                    cnt <= CONV_LEN;
                end
                CONV: begin
                    bcd <= bcd_nxt;
                    sh  <= sh << 1;
                    cnt <= cnt - CW'(1);
                    // Digits commit together on the last step so the display never shows a torn value.
                    if (cnt == CW'(1)) begin
`ifdef HEX_MODE_EN
                        tens <= 4'(8'(sh) >> 4);
                        ones <= 4'(sh);
`else
                        tens <= bcd_nxt[7:4];
                        ones <= bcd_nxt[3:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Refresh divider free-runs regardless of conversion activity.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rcnt    <= '0;
            sel     <= 1'b0;
            bus.An  <= 4'b1110;
            bus.Seg <= 7'b1000000;
        end else begin
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                sel  <= ~sel;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            if (!sel) begin
                bus.An  <= 4'b1110;
                bus.Seg <= seg_pat(ones);
            end else if (tens == 4'd0) begin
                bus.An  <= 4'b1111;
                bus.Seg <= 7'b1111111;
            end else begin
                bus.An  <= 4'b1101;
                bus.Seg <= seg_pat(tens);
            end
        end
    end
endmodule

// File: tb/tb_sum_display_driver.sv
// Randomized scoreboard bench for sum_display_driver; honours HEX_MODE_EN like the design.
module tb_sum_display_driver;
    localparam int SUM_W = 5;
    localparam int RD    = 4;
`ifdef HEX_MODE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = SUM_W;
`endif

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        int         lat;
    } exp_t;

    logic Clk, Rst_n;
    sum_display_driver_if #(.SUM_W(SUM_W)) bus();

    sum_display_driver #(.SUM_W(SUM_W), .REFRESH_DIV(RD)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   remaining = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: the displayed digits are simply the value in base 10 (or 16).
    function automatic exp_t model(input int v);
        exp_t e;
`ifdef HEX_MODE_EN
        e.tens = 4'(v / 16);
        e.ones = 4'(v % 16);
`else
        e.tens = 4'(v / 10);
        e.ones = 4'(v % 10);
`endif
        e.lat = LAT;
        return e;
    endfunction

    // A load is accepted only when no conversion is outstanding.
    task automatic step(input logic ld, input logic [SUM_W-1:0] s);
        @(negedge Clk);
        bus.Load = ld;
        bus.Sum  = s;
        @(posedge Clk);
        if (!Rst_n)             remaining = 0;
        else if (remaining > 0) remaining--;
        else if (ld) begin
            sb.push_back(model(int'(s)));
            remaining = LAT;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, SUM_W'($urandom));
    endtask

    // Monitor: times each Busy pulse, then checks the digits shown for one full refresh period.
    int   bcnt = 0, wcnt = 0;
    logic pbusy = 1'b0, win = 1'b0, saw_o = 1'b0, saw_t = 1'b0;
    exp_t cur;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            bcnt = 0; pbusy = 1'b0; win = 1'b0;
        end else begin
            if (bus.Busy) begin
                bcnt++;
                win = 1'b0;
            end else if (pbusy) begin
                if (sb.size() == 0) chk("unexpected_commit", 1, 0);
                else begin
                    cur = sb.pop_front();
                    chk("busy_len", bcnt, cur.lat);
                    win = 1'b1; wcnt = 0; saw_o = 1'b0; saw_t = 1'b0;
                end
                bcnt = 0;
            end else if (win) begin
                case (bus.An)
                    4'b1110: begin
                        chk("ones_seg", int'(bus.Seg), int'(pat[cur.ones]));
                        saw_o = 1'b1;
                    end
                    4'b1101: begin
                        chk("tens_not_blank", int'(cur.tens != 4'd0), 1);
                        chk("tens_seg", int'(bus.Seg), int'(pat[cur.tens]));
                        saw_t = 1'b1;
                    end
                    4'b1111: begin
                        chk("tens_blank", int'(cur.tens), 0);
                        chk("blank_seg", int'(bus.Seg), 7'h7F);
                        saw_t = 1'b1;
                    end
                    default: chk("an_legal", int'(bus.An), 4'b1110);
                endcase
                wcnt++;
                if (wcnt == 2 * RD + 1) begin
                    chk("ones_slot_seen", int'(saw_o), 1);
                    chk("tens_slot_seen", int'(saw_t), 1);
                    win = 1'b0;
                end
            end
            pbusy = bus.Busy;
        end
    end

    // Display must read "0": ones slot shows 0, tens slot blanked, slots alternate every RD cycles.
    task automatic check_zero_display(input string tag);
        logic [3:0] prev;
        int last = -1;
        @(negedge Clk);
        prev = bus.An;
        for (int i = 1; i < 4 * RD + 2; i++) begin
            @(negedge Clk);
            if (bus.An == 4'b1110) chk({tag, "_seg0"}, int'(bus.Seg), 7'b1000000);
            else                   chk({tag, "_an_blank"}, int'(bus.An), 4'b1111);
            if (bus.An != prev) begin
                if (last >= 0) chk({tag, "_refresh_gap"}, i - last, RD);
                last = i;
            end
            prev = bus.An;
        end
        chk({tag, "_toggled"}, int'(last >= 0), 1);
    endtask

    logic [SUM_W-1:0] dir [6] = '{5'd13, 5'd30, 5'd31, 5'd0, 5'h1E, 5'd9};

    initial begin
        bus.Load = 1'b0;
        bus.Sum  = '0;
        Rst_n    = 1'b0;
        // Load asserted while in reset must not start anything.
        for (int i = 0; i < 3; i++) step(1'b1, 5'd17);
        #1;
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_an", int'(bus.An), 4'b1110);
        chk("rst_seg", int'(bus.Seg), 7'b1000000);
        @(negedge Clk);
        bus.Load = 1'b0;
        #2 Rst_n = 1'b1;
        check_zero_display("post_reset");

        // Directed values, each with a Load attempt and Sum churn while busy.
        foreach (dir[i]) begin
            step(1'b1, dir[i]);
            step(1'b0, 5'd7);
            step(1'b1, 5'd7);
            step(1'b0, SUM_W'($urandom));
            idle(2 * RD + LAT + 4);
        end

        // Load held high: one re-capture per IDLE edge after each commit.
        for (int i = 0; i < 3 * (LAT + 1); i++) step(1'b1, SUM_W'($urandom));
        idle(2 * RD + LAT + 4);

        // Randomized traffic with random gaps and stray loads.
        for (int n = 0; n < 40; n++) begin
            step(1'b1, SUM_W'($urandom));
            for (int g = $urandom_range(0, 3 * RD + LAT); g > 0; g--)
                step(($urandom_range(0, 4) == 0), SUM_W'($urandom));
        end
        idle(2 * RD + LAT + 4);

        // Reset two edges into a conversion: aborted, digits cleared, nothing commits later.
        step(1'b1, 5'd25);
        step(1'b0, 5'd25);
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.Busy), 0);
        chk("midrst_an", int'(bus.An), 4'b1110);
        chk("midrst_seg", int'(bus.Seg), 7'b1000000);
        sb.delete();
        remaining = 0;
        step(1'b1, 5'd25);
        step(1'b1, 5'd25);
        @(negedge Clk);
        bus.Load = 1'b0;
        #2 Rst_n = 1'b1;
        check_zero_display("midrst");
        idle(2 * RD + LAT + 4);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_display_driver.md
Name: sum_display_driver

Overview:
Sequential output stage that sits downstream of AdderTop. It captures the 5-bit adder sum on a load strobe and converts it to two decimal digits with an iterative double-dabble FSM. It then time-multiplexes those digits onto an active-low four-digit seven-segment display. It is the consumer end of the adder's Output bus, complementing the switch/button input side.

Parameters:
SUM_W, 5, width of Sum input; legal range 1..6 (max value < 100, two BCD digits)
REFRESH_DIV, 50000, clock cycles each digit is held before the display mux advances; legal ≥ 2

Ports:
Clk  input  1  single system clock, rising edge
Rst_n  input  1  asynchronous, active-low reset
Sum  input  SUM_W  binary sum from adder (Output bus)
Load  input  1  capture request; sampled only in IDLE
Busy  output  1  high while a conversion is in progress
Seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}
An  output  4  active-low digit anodes; An[0]=ones, An[1]=tens, An[3:2] always 1

Behaviour:
- Reset (Rst_n low, async): FSM=IDLE, Busy=0, committed digits Tens=0, Ones=0, refresh counter=0, digit select=0, An=4'b1110, Seg=7'b1000000 ("0").
- FSM states:
  - IDLE: Load=1 at edge k captures Sum into a shift register, clears the BCD scratch, loads bit count=SUM_W, goes to CONV, Busy=1 after edge k.
  - CONV: each edge does add-3 on any BCD nibble ≥5, then shifts left one bit.
  - After SUM_W CONV edges (edge k+SUM_W): commit Tens/Ones atomically, Busy=0, return to IDLE.
- Busy is high for exactly SUM_W cycles.
- Load while Busy is ignored, with no queueing. Sum changes during CONV have no effect.
- Back-to-back: Load held high re-captures on the first IDLE edge after commit.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On the edge where the counter equals REFRESH_DIV-1, the counter returns to 0 and digit select toggles.
- Seg and An are registered, updated every edge from the current select and committed digits. One cycle of lag after a commit or toggle is permitted.
- Select=0: An=1110, Seg=pattern(Ones).
- Select=1: An=1101, Seg=pattern(Tens).
- Leading-zero blanking: if Tens=0, select=1 drives An=1111 and Seg=1111111.
- Digit patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Boundary conditions:
  - Reset asserted mid-CONV aborts the conversion; previously committed digits are cleared to 0.
  - Load coincident with Rst_n low: reset wins.
  - Sum=0 displays "0". Maximum 5-bit sum 31 displays "31".

Optional Feature:
HEX_MODE_EN
- Defined:
  - No decimal conversion; Load at edge k commits Tens={3'b0,Sum[4]} and Ones=Sum[3:0] at edge k+1, with Busy high for exactly 1 cycle.
  - Additional patterns: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Blanking rule unchanged.
- Undefined: decimal behaviour as above. Only patterns 0-9 are reachable.

Test Plan:
1. Reset with Rst_n=0 mid-run, Rst_n=1, REFRESH_DIV=4 -> Busy=0, An=1110, Seg=1000000; An stays 1111 during select=1 slots (tens blank).
2. Sum=5'd13, Load pulse at edge k -> Busy=1 for edges k..k+4, 0 after k+5. Then An=1110 shows Seg=0110000 ("3"); An=1101 shows Seg=1111001 ("1"). Alternation every 4 cycles.
3. Sum=5'd30 loaded, then Sum changed to 5'd7 and Load re-pulsed while Busy -> display "30" (Tens=0110000, Ones=1000000); second Load ignored, Busy not extended.
4. Sum=5'd31 load -> digits "3","1". Then Sum=5'd0 load -> An[1] blanked, ones=1000000.
5. Load Sum=5'd25, assert Rst_n=0 at edge k+2 -> Busy=0 immediately, display "0", no later commit after Rst_n=1.
6. HEX_MODE_EN defined, Sum=5'h1E, Load -> Busy high 1 cycle; tens Seg=1111001 ("1"), ones Seg=0000110 ("E").
